digit_sequencer: RTL
====================

DIGIT_SEQUENCER -- requirements
Module: digit_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 1000, meaning clock cycles each digit is held.
REQ-002 SHALL have parameter GAP, default 250, meaning blank cycles after each digit.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load, input, 1, single-cycle request to display value.
REQ-006 SHALL have port value, input, 8, unsigned binary number to display.
REQ-007 SHALL have port digit, output, 4, registered BCD digit for the downstream 7-segment decoder; 4'hF is blank.
REQ-008 SHALL have port dp, output, 1, registered; high while the final (ones) digit shows.
REQ-009 SHALL have port busy, output, 1, registered; high in every state except IDLE.

Function
REQ-010 SHALL implement states IDLE, CONV, SHOW, BLANK.
REQ-011 IDLE: digit=4'hF, dp=0; load=1 captures value and enters CONV next cycle.
REQ-012 load SHALL be ignored while busy=1; no queuing.
REQ-013 CONV SHALL run sequential double-dabble: exactly 8 cycles, one shift per cycle, add-3 to any BCD nibble >=5 before each shift, 12-bit BCD result (hundreds, tens, ones).
REQ-014 The first digit SHALL appear on digit 9 cycles after the load cycle (load at edge N -> digit valid after edge N+9).
REQ-015 SHOW SHALL drive the current BCD digit for exactly DWELL cycles, then enter BLANK.
REQ-016 BLANK SHALL drive 4'hF, dp=0 for exactly GAP cycles, then SHOW the next digit, or IDLE after the ones digit.
REQ-017 Digit order SHALL be hundreds, tens, ones; ones is always shown (value 0 shows a single "0").
REQ-018 dp SHALL be 1 exactly during the ones-digit SHOW cycles.
REQ-019 The dwell/gap counter SHALL be wide enough for max(DWELL,GAP); DWELL>=1 and GAP>=0 are legal; GAP=0 skips BLANK entirely.
REQ-020 busy SHALL fall in the same cycle IDLE is entered; load asserted in that IDLE cycle SHALL be accepted.
REQ-021 value SHALL be sampled only in the load cycle; later value changes SHALL not affect the display.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, digit=4'hF, dp=0, busy=0, and clear counters and BCD register.
REQ-023 Reset asserted mid-CONV/SHOW/BLANK SHALL abort the sequence; no digit resumes after release.
REQ-024 After rst_n release the first accepted load SHALL follow REQ-014 timing exactly.

Configuration
REQ-025 Macro DIGIT_SEQUENCER_LZS_EN SHALL control leading-zero suppression.
REQ-026 With DIGIT_SEQUENCER_LZS_EN defined: a zero hundreds digit is skipped (no SHOW, no BLANK); a zero tens digit is skipped when hundreds is also zero; the first shown digit still appears at N+9.
REQ-027 Without it: all three digits are always shown, including leading zeros.

Verification (bench parameters DWELL=4, GAP=2)
REQ-028 load with value=8'd255 -> after 8 CONV cycles digit sequence 2 x4, F x2, 5 x4, F x2, 5 x4 (dp=1), F x2, then IDLE with busy=0.
REQ-029 value=8'd7 with LZS_EN -> only 7 x4 (dp=1), F x2; without LZS_EN -> 0,F,0,F,7(dp=1),F at the same per-digit durations.
REQ-030 value=8'd0 with LZS_EN -> single 0 x4 with dp=1, total busy time 8+4+2=14 cycles.
REQ-031 Second load pulse (value=8'd99) during SHOW of first number -> ignored; load asserted in the first IDLE cycle -> accepted, first digit at N+9.
REQ-032 rst_n pulsed low during tens SHOW of value 8'd123 -> digit=F, busy=0 immediately (asynchronous), nothing further displayed after release.
REQ-033 value changed every cycle after load of 8'd150 -> displayed digits remain 1,5,0.

Source files
------------

// File: rtl/digit_sequencer.sv
// ---------------------------------------------------------------------------
// digit_sequencer
//
// Takes an 8-bit binary number on a single-cycle load pulse and converts it
// to three BCD digits with a sequential double-dabble, then presents them one
// at a time on a 4-bit digit bus for a downstream 7-segment decoder. The order
// is hundreds, tens, ones. Each digit is held for DWELL cycles and followed by
// GAP blank cycles. 4'hF is the blank code.
//
// Timing: if load is sampled at rising edge N+1, the CONV state occupies the
// eight cycles that follow. The first digit is registered at edge N+9.
//
// Optional feature: define DIGIT_SEQUENCER_LZS_EN to enable leading-zero
// suppression. When it is enabled, a zero hundreds digit is skipped. A zero
// tens digit is also skipped when the hundreds digit is zero. The ones digit
// is always shown. The default build shows all three digits.
// ---------------------------------------------------------------------------
module digit_sequencer #(
  parameter int DWELL = 1000,  // cycles each digit is held (>= 1)
  parameter int GAP   = 250    // blank cycles after each digit (>= 0)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic [3:0] digit,
  output logic       dp,
  output logic       busy
);

  // One down-counter serves CONV (8 steps), SHOW (DWELL) and BLANK (GAP).
  localparam int MAX_DG  = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_MAX = (MAX_DG > 8) ? MAX_DG : 8;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CONV_LOAD  = CNT_W'(7);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [3:0]       BLANK_CODE = 4'hF;

  // Digit index: 2 = hundreds, 1 = tens, 0 = ones.
  localparam logic [1:0] IDX_HUN  = 2'd2;
  localparam logic [1:0] IDX_ONES = 2'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SHOW,
    S_BLANK
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_bin;     // binary shift register, MSB first
  logic [11:0]      r_bcd;     // {hundreds, tens, ones}
  logic [1:0]       r_idx;     // digit currently being shown
  logic [3:0]       r_digit;
  logic             r_dp;
  logic             r_busy;

  logic [11:0]      w_bcd_adj;
  logic [11:0]      w_bcd_next;
  logic [1:0]       w_first_idx;
  logic [1:0]       w_next_idx;

  // Select one BCD nibble by digit index.
  function automatic logic [3:0] pick_nibble(input logic [11:0] bcd,
                                             input logic [1:0]  idx);
    case (idx)
      2'd2:    pick_nibble = bcd[11:8];
      2'd1:    pick_nibble = bcd[7:4];
      default: pick_nibble = bcd[3:0];
    endcase
  endfunction

  // Double-dabble adjust step: add 3 to every nibble that is >= 5.
  // NOTE: every variable driven from always_comb gets a default assignment
  // before any conditional update, so no latch can be inferred.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // The shift brings in the next binary bit. The top BCD bit falls off and is
  // always zero for an 8-bit input.
  assign w_bcd_next = 12'({w_bcd_adj, r_bin[7]});

  // First digit to show once the conversion finishes.
`ifdef DIGIT_SEQUENCER_LZS_EN
  assign w_first_idx = (w_bcd_next[11:8] != 4'd0) ? 2'd2 :
                       (w_bcd_next[7:4]  != 4'd0) ? 2'd1 : 2'd0;
`else
  assign w_first_idx = IDX_HUN;
`endif

  assign w_next_idx = r_idx - 2'd1;

  // Sequencer FSM. The state, counter, datapath and all outputs are registered here.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values of the others regardless of statement order.
  // NOTE: the BCD and binary shift registers are ordinary flops, not a memory.
  // They are cleared by reset so that an aborted conversion leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_idx   <= IDX_ONES;
      r_digit <= BLANK_CODE;
      r_dp    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin   <= value;
            r_bcd   <= '0;
            r_cnt   <= CONV_LOAD;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end

        S_CONV: begin
          r_bcd <= w_bcd_next;
          r_bin <= {r_bin[6:0], 1'b0};
          if (r_cnt == '0) begin
            // The last shift completes here, so the result comes from the
            // combinational next value rather than from r_bcd.
            r_idx   <= w_first_idx;
            r_digit <= pick_nibble(w_bcd_next, w_first_idx);
            r_dp    <= (w_first_idx == IDX_ONES);
            r_cnt   <= DWELL_LOAD;
            r_state <= S_SHOW;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_SHOW: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (GAP > 0) begin
            r_digit <= BLANK_CODE;
            r_dp    <= 1'b0;
            r_cnt   <= GAP_LOAD;
            r_state <= S_BLANK;
          end else if (r_idx == IDX_ONES) begin
            r_digit <= BLANK_CODE;
            r_dp    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // With a zero gap, the next digit follows immediately.
            r_idx   <= w_next_idx;
            r_digit <= pick_nibble(r_bcd, w_next_idx);
            r_dp    <= (w_next_idx == IDX_ONES);
            r_cnt   <= DWELL_LOAD;
          end
        end

        S_BLANK: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_idx == IDX_ONES) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= w_next_idx;
            r_digit <= pick_nibble(r_bcd, w_next_idx);
            r_dp    <= (w_next_idx == IDX_ONES);
            r_cnt   <= DWELL_LOAD;
            r_state <= S_SHOW;
          end
        end

        default: begin
          r_digit <= BLANK_CODE;
          r_dp    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign digit = r_digit;
  assign dp    = r_dp;
  assign busy  = r_busy;

endmodule
